// File: rtl/spu_dual_issue_queue.sv
// Decoded-instruction buffer feeding the SPU even/odd pipes.
// Issues one or two instructions per cycle in program order, halts on stop, supports flush.
module spu_dual_issue_queue #(
   parameter int DEPTH      = 8,
   parameter int PAYLOAD_W  = 32,
   parameter int DUAL_ISSUE = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [0:1]              in_valid,
   input  logic [6:0]              in_opcode0,
   input  logic [6:0]              in_opcode1,
   input  logic [PAYLOAD_W-1:0]    in_payload0,
   input  logic [PAYLOAD_W-1:0]    in_payload1,
   output logic                    in_ready,
   output logic                    even_valid,
   output logic                    odd_valid,
   output logic [6:0]              even_opcode,
   output logic [6:0]              odd_opcode,
   output logic [PAYLOAD_W-1:0]    even_payload,
   output logic [PAYLOAD_W-1:0]    odd_payload,
   output logic                    even_illegal,
   output logic                    even_older,
   input  logic                    even_ready,
   input  logic                    odd_ready,
   output logic                    issue_fire,
   input  logic                    flush,
   input  logic                    resume,
   output logic                    halted,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {ST_RUN, ST_HALTED} state_t;
   typedef enum logic [1:0] {CLS_EVEN, CLS_ODD, CLS_ILL} cls_t;

   function automatic cls_t op_class(input logic [6:0] op);
      if (op == 7'd0 || op == 7'd8 || op >= 7'd95) return CLS_ILL;
      else if ((op >= 7'd67 && op <= 7'd92) || op == 7'd94) return CLS_ODD;
      else return CLS_EVEN;
   endfunction

   state_t               state_q, state_d;
   logic [AW-1:0]        rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]        count_q, count_d;
   logic [6:0]           op_mem [DEPTH];
   logic [PAYLOAD_W-1:0] pl_mem [DEPTH];

   logic [AW-1:0] rd1, wr1;
   logic [6:0]    i0_op, i1_op;
   cls_t          cls0, cls1;
   logic          i0_v, i0_even, ends_group, pair;
   logic          enq, enq2;
   logic [CW-1:0] n_enq, n_iss;

   assign rd1 = rd_q + AW'(1);
   assign wr1 = wr_q + AW'(1);

   // Group selection looks only at registered queue state, never at the pipe readies.
   always_comb begin
      i0_op      = op_mem[rd_q];
      i1_op      = op_mem[rd1];
      cls0       = op_class(i0_op);
      cls1       = op_class(i1_op);
      i0_v       = (count_q != '0) && (state_q == ST_RUN);
      i0_even    = (cls0 != CLS_ODD);
      ends_group = (i0_op >= 7'd84) && (i0_op <= 7'd92);
      pair       = (DUAL_ISSUE != 0) && i0_v && (count_q >= CW'(2)) && (cls0 != cls1)
                   && !ends_group && (cls0 != CLS_ILL) && (cls1 != CLS_ILL);
   end

   always_comb begin
      even_valid   = i0_v && (i0_even || pair);
      odd_valid    = i0_v && (!i0_even || pair);
      even_opcode  = '0;
      even_payload = '0;
      odd_opcode   = '0;
      odd_payload  = '0;
      if (even_valid) begin
         even_opcode  = i0_even ? i0_op : i1_op;
         even_payload = i0_even ? pl_mem[rd_q] : pl_mem[rd1];
      end
      if (odd_valid) begin
         odd_opcode  = i0_even ? i1_op : i0_op;
         odd_payload = i0_even ? pl_mem[rd1] : pl_mem[rd_q];
      end
      // Illegal opcodes only ever reach the even slot, and always as I0.
      even_illegal = even_valid && i0_even && (cls0 == CLS_ILL);
      even_older   = !(pair && !i0_even);
      issue_fire   = i0_v && (!even_valid || even_ready) && (!odd_valid || odd_ready) && !flush;
   end

   assign in_ready = (count_q <= CW'(DEPTH - 2)) && !flush;
   assign enq      = in_valid[0] && in_ready;
   assign enq2     = enq && in_valid[1];
   assign n_enq    = enq2 ? CW'(2) : (enq ? CW'(1) : CW'(0));
   assign n_iss    = issue_fire ? (pair ? CW'(2) : CW'(1)) : CW'(0);

   always_comb begin
      if (flush) begin
         count_d = '0;
         rd_d    = '0;
         wr_d    = '0;
      end else begin
         count_d = count_q + n_enq - n_iss;
         rd_d    = rd_q + n_iss[AW-1:0];
         wr_d    = wr_q + n_enq[AW-1:0];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:    if (issue_fire && odd_valid && odd_opcode == 7'd92) state_d = ST_HALTED;
         ST_HALTED: if (resume) state_d = ST_RUN;
         default:   state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: entries are only read once count covers them.
   always_ff @(posedge clk) begin
      if (enq) begin
         op_mem[wr_q] <= in_opcode0;
         pl_mem[wr_q] <= in_payload0;
      end
      if (enq2) begin
         op_mem[wr1] <= in_opcode1;
         pl_mem[wr1] <= in_payload1;
      end
   end

   assign halted = (state_q == ST_HALTED);
   assign count  = count_q;

endmodule

// File: tb/tb_spu_dual_issue_queue.sv
// Self-checking bench for spu_dual_issue_queue: vector table, hand sequences,
// random traffic, and an in-order scoreboard of every issued instruction.
module tb_spu_dual_issue_queue;

   localparam int DEPTH = 8;
   localparam int PW    = 32;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic [0:1]    in_valid;
   logic [6:0]    in_opcode0, in_opcode1;
   logic [PW-1:0] in_payload0, in_payload1;
   logic          even_ready, odd_ready, flush, resume;

   logic          in_ready, even_valid, odd_valid, even_illegal, even_older, issue_fire, halted;
   logic [6:0]    even_opcode, odd_opcode;
   logic [PW-1:0] even_payload, odd_payload;
   logic [CW-1:0] count;

   logic          d1_in_ready, d1_even_valid, d1_odd_valid, d1_even_illegal, d1_even_older;
   logic          d1_issue_fire, d1_halted;
   logic [6:0]    d1_even_opcode, d1_odd_opcode;
   logic [PW-1:0] d1_even_payload, d1_odd_payload;
   logic [CW-1:0] d1_count;

   always #5 clk = ~clk;

   spu_dual_issue_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW), .DUAL_ISSUE(1)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid),
      .in_opcode0(in_opcode0), .in_opcode1(in_opcode1),
      .in_payload0(in_payload0), .in_payload1(in_payload1),
      .in_ready(in_ready), .even_valid(even_valid), .odd_valid(odd_valid),
      .even_opcode(even_opcode), .odd_opcode(odd_opcode),
      .even_payload(even_payload), .odd_payload(odd_payload),
      .even_illegal(even_illegal), .even_older(even_older),
      .even_ready(even_ready), .odd_ready(odd_ready), .issue_fire(issue_fire),
      .flush(flush), .resume(resume), .halted(halted), .count(count)
   );

   spu_dual_issue_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW), .DUAL_ISSUE(0)) u_dut_single (
      .clk(clk), .reset(reset), .in_valid(in_valid),
      .in_opcode0(in_opcode0), .in_opcode1(in_opcode1),
      .in_payload0(in_payload0), .in_payload1(in_payload1),
      .in_ready(d1_in_ready), .even_valid(d1_even_valid), .odd_valid(d1_odd_valid),
      .even_opcode(d1_even_opcode), .odd_opcode(d1_odd_opcode),
      .even_payload(d1_even_payload), .odd_payload(d1_odd_payload),
      .even_illegal(d1_even_illegal), .even_older(d1_even_older),
      .even_ready(even_ready), .odd_ready(odd_ready), .issue_fire(d1_issue_fire),
      .flush(flush), .resume(resume), .halted(d1_halted), .count(d1_count)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Pipe class model: 0 even, 1 odd, 2 illegal.
   function automatic int cls(input logic [6:0] op);
      if (op == 7'd0 || op == 7'd8 || op >= 7'd95) return 2;
      if ((op >= 7'd67 && op <= 7'd92) || op == 7'd94) return 1;
      return 0;
   endfunction

   typedef struct {
      logic [6:0]  op;
      logic [31:0] pl;
   } sb_t;
   sb_t sb_q[$];

   task automatic check_slot(input logic is_even);
      sb_t e;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL sb_underflow: got issue with empty scoreboard, expected none");
         return;
      end
      e = sb_q.pop_front();
      chk("sb_pipe", 32'(is_even), 32'(cls(e.op) != 1));
      if (is_even) begin
         chk("sb_even_op", 32'(even_opcode), 32'(e.op));
         chk("sb_even_pl", even_payload, e.pl);
         chk("sb_even_ill", 32'(even_illegal), 32'(cls(e.op) == 2));
      end else begin
         chk("sb_odd_op", 32'(odd_opcode), 32'(e.op));
         chk("sb_odd_pl", odd_payload, e.pl);
      end
   endtask

   // Scoreboard monitor: counts/readiness against the model, issued groups in program order.
   always @(negedge clk) begin
      logic accept;
      if (reset) begin
         sb_q.delete();
      end else begin
         accept = (sb_q.size() <= DEPTH - 2) && !flush;
         chk("count", 32'(count), 32'(sb_q.size()));
         chk("in_ready", 32'(in_ready), 32'(accept));
         if (issue_fire) begin
            $display("issue t=%0t even=%0b/%0d odd=%0b/%0d even_older=%0b",
                     $time, even_valid, even_opcode, odd_valid, odd_opcode, even_older);
            if (even_valid && odd_valid) begin
               check_slot(even_older);
               check_slot(!even_older);
            end else if (even_valid) begin
               check_slot(1'b1);
            end else if (odd_valid) begin
               check_slot(1'b0);
            end else begin
               n_checks++;
               n_errors++;
               $display("FAIL fire_empty: got issue_fire=1, expected 0 with no valid slot");
            end
         end
         if (flush) begin
            sb_q.delete();
         end else if (in_valid[0] && accept) begin
            sb_q.push_back('{in_opcode0, in_payload0});
            if (in_valid[1]) sb_q.push_back('{in_opcode1, in_payload1});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic enq(input logic [0:1] v, input logic [6:0] a, input logic [6:0] b);
      in_valid    = v;
      in_opcode0  = a;
      in_opcode1  = b;
      in_payload0 = $urandom;
      in_payload1 = $urandom;
      tick();
      in_valid = 2'b00;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   typedef struct {
      logic [0:1] vld;
      logic [6:0] op0, op1;
      logic       er, orr;
      logic       ev;
      logic [6:0] eop;
      logic       ov;
      logic [6:0] oop;
      logic       older, ill, fire;
   } vec_t;

   vec_t vecs[17];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected simulation end");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] ops_tbl [12];
      int r;
      bit drained;

      //            vld    op0    op1    er   orr   ev   eop    ov   oop    older ill  fire
      vecs[0]  = '{2'b11, 7'd1,  7'd81, 1'b1, 1'b1, 1'b1, 7'd1,  1'b1, 7'd81, 1'b1, 1'b0, 1'b1};
      vecs[1]  = '{2'b11, 7'd81, 7'd1,  1'b1, 1'b1, 1'b1, 7'd1,  1'b1, 7'd81, 1'b0, 1'b0, 1'b1};
      vecs[2]  = '{2'b11, 7'd17, 7'd13, 1'b1, 1'b1, 1'b1, 7'd17, 1'b0, 7'd0,  1'b1, 1'b0, 1'b1};
      vecs[3]  = '{2'b11, 7'd84, 7'd17, 1'b1, 1'b1, 1'b0, 7'd0,  1'b1, 7'd84, 1'b1, 1'b0, 1'b1};
      vecs[4]  = '{2'b11, 7'd8,  7'd81, 1'b1, 1'b1, 1'b1, 7'd8,  1'b0, 7'd0,  1'b1, 1'b1, 1'b1};
      vecs[5]  = '{2'b11, 7'd1,  7'd8,  1'b1, 1'b1, 1'b1, 7'd1,  1'b0, 7'd0,  1'b1, 1'b0, 1'b1};
      vecs[6]  = '{2'b11, 7'd93, 7'd94, 1'b1, 1'b1, 1'b1, 7'd93, 1'b1, 7'd94, 1'b1, 1'b0, 1'b1};
      vecs[7]  = '{2'b11, 7'd94, 7'd93, 1'b1, 1'b1, 1'b1, 7'd93, 1'b1, 7'd94, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{2'b11, 7'd66, 7'd67, 1'b1, 1'b1, 1'b1, 7'd66, 1'b1, 7'd67, 1'b1, 1'b0, 1'b1};
      vecs[9]  = '{2'b11, 7'd127,7'd1,  1'b1, 1'b1, 1'b1, 7'd127,1'b0, 7'd0,  1'b1, 1'b1, 1'b1};
      vecs[10] = '{2'b11, 7'd1,  7'd81, 1'b1, 1'b0, 1'b1, 7'd1,  1'b1, 7'd81, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{2'b11, 7'd91, 7'd1,  1'b1, 1'b1, 1'b0, 7'd0,  1'b1, 7'd91, 1'b1, 1'b0, 1'b1};
      vecs[12] = '{2'b11, 7'd83, 7'd1,  1'b1, 1'b1, 1'b1, 7'd1,  1'b1, 7'd83, 1'b0, 1'b0, 1'b1};
      vecs[13] = '{2'b10, 7'd81, 7'd1,  1'b1, 1'b1, 1'b0, 7'd0,  1'b1, 7'd81, 1'b1, 1'b0, 1'b1};
      vecs[14] = '{2'b11, 7'd7,  7'd9,  1'b1, 1'b1, 1'b1, 7'd7,  1'b0, 7'd0,  1'b1, 1'b0, 1'b1};
      vecs[15] = '{2'b01, 7'd1,  7'd81, 1'b1, 1'b1, 1'b0, 7'd0,  1'b0, 7'd0,  1'b1, 1'b0, 1'b0};
      vecs[16] = '{2'b11, 7'd1,  7'd81, 1'b0, 1'b1, 1'b1, 7'd1,  1'b1, 7'd81, 1'b1, 1'b0, 1'b0};

      ops_tbl = '{7'd1, 7'd13, 7'd17, 7'd66, 7'd93, 7'd67, 7'd81, 7'd83, 7'd84, 7'd94, 7'd8, 7'd127};

      // Reset with random inputs on the control lines
      reset = 1'b1;
      flush = 1'b0;
      repeat (2) begin
         in_valid    = 2'($urandom_range(0, 3));
         in_opcode0  = 7'($urandom);
         in_opcode1  = 7'($urandom);
         in_payload0 = $urandom;
         in_payload1 = $urandom;
         even_ready  = 1'($urandom);
         odd_ready   = 1'($urandom);
         resume      = 1'($urandom);
         tick();
      end
      @(negedge clk);
      chk("rst_even_valid", 32'(even_valid), 32'd0);
      chk("rst_odd_valid", 32'(odd_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_even_older", 32'(even_older), 32'd1);
      chk("rst_fire", 32'(issue_fire), 32'd0);
      tick();
      reset      = 1'b0;
      in_valid   = 2'b00;
      even_ready = 1'b1;
      odd_ready  = 1'b1;
      resume     = 1'b0;
      tick();

      // Table-driven group formation
      for (int i = 0; i < 17; i++) begin
         even_ready = vecs[i].er;
         odd_ready  = vecs[i].orr;
         enq(vecs[i].vld, vecs[i].op0, vecs[i].op1);
         @(negedge clk);
         chk($sformatf("v%0d_even_valid", i), 32'(even_valid), 32'(vecs[i].ev));
         chk($sformatf("v%0d_even_opcode", i), 32'(even_opcode), 32'(vecs[i].eop));
         chk($sformatf("v%0d_odd_valid", i), 32'(odd_valid), 32'(vecs[i].ov));
         chk($sformatf("v%0d_odd_opcode", i), 32'(odd_opcode), 32'(vecs[i].oop));
         chk($sformatf("v%0d_even_older", i), 32'(even_older), 32'(vecs[i].older));
         chk($sformatf("v%0d_even_illegal", i), 32'(even_illegal), 32'(vecs[i].ill));
         chk($sformatf("v%0d_issue_fire", i), 32'(issue_fire), 32'(vecs[i].fire));
         tick();
         even_ready = 1'b1;
         odd_ready  = 1'b1;
         do_flush();
      end

      // Two same-class instructions issue singly on consecutive cycles
      enq(2'b11, 7'd17, 7'd13);
      @(negedge clk);
      chk("seq_or_op", 32'(even_opcode), 32'd17);
      chk("seq_or_fire", 32'(issue_fire), 32'd1);
      chk("seq_or_odd", 32'(odd_valid), 32'd0);
      tick();
      @(negedge clk);
      chk("seq_add_op", 32'(even_opcode), 32'd13);
      chk("seq_add_fire", 32'(issue_fire), 32'd1);
      tick();
      @(negedge clk);
      chk("seq_empty_valid", 32'(even_valid), 32'd0);

      // Single-issue build splits a legal pair over two cycles
      tick();
      enq(2'b11, 7'd1, 7'd81);
      @(negedge clk);
      chk("si_c1_even_valid", 32'(d1_even_valid), 32'd1);
      chk("si_c1_even_op", 32'(d1_even_opcode), 32'd1);
      chk("si_c1_odd_valid", 32'(d1_odd_valid), 32'd0);
      chk("si_c1_fire", 32'(d1_issue_fire), 32'd1);
      tick();
      @(negedge clk);
      chk("si_c2_odd_valid", 32'(d1_odd_valid), 32'd1);
      chk("si_c2_odd_op", 32'(d1_odd_opcode), 32'd81);
      chk("si_c2_even_valid", 32'(d1_even_valid), 32'd0);
      chk("si_c2_fire", 32'(d1_issue_fire), 32'd1);
      tick();
      @(negedge clk);
      chk("si_count", 32'(d1_count), 32'd0);
      tick();

      // Stop halts issue until resume
      enq(2'b11, 7'd92, 7'd1);
      @(negedge clk);
      chk("stop_odd_op", 32'(odd_opcode), 32'd92);
      chk("stop_even_valid", 32'(even_valid), 32'd0);
      chk("stop_fire", 32'(issue_fire), 32'd1);
      tick();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("halt%0d_halted", c), 32'(halted), 32'd1);
         chk($sformatf("halt%0d_valid", c), 32'({even_valid, odd_valid}), 32'd0);
         chk($sformatf("halt%0d_count", c), 32'(count), 32'd1);
         chk($sformatf("halt%0d_fire", c), 32'(issue_fire), 32'd0);
         tick();
      end
      resume = 1'b1;
      tick();
      resume = 1'b0;
      @(negedge clk);
      chk("resume_halted", 32'(halted), 32'd0);
      chk("resume_even_op", 32'(even_opcode), 32'd1);
      chk("resume_fire", 32'(issue_fire), 32'd1);
      tick();
      do_flush();

      // Atomic group under back-pressure
      odd_ready = 1'b0;
      enq(2'b11, 7'd1, 7'd81);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("bp%0d_fire", c), 32'(issue_fire), 32'd0);
         chk($sformatf("bp%0d_even", c), 32'({even_valid, even_opcode}), 32'({1'b1, 7'd1}));
         chk($sformatf("bp%0d_odd", c), 32'({odd_valid, odd_opcode}), 32'({1'b1, 7'd81}));
         tick();
      end
      odd_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_fire", 32'(issue_fire), 32'd1);
      tick();
      @(negedge clk);
      chk("bp_count", 32'(count), 32'd0);
      tick();
      do_flush();

      // Fill to DEPTH-1, then flush
      even_ready = 1'b0;
      odd_ready  = 1'b0;
      enq(2'b11, 7'd1, 7'd81);
      enq(2'b11, 7'd17, 7'd83);
      enq(2'b11, 7'd13, 7'd67);
      @(negedge clk);
      chk("fill6_count", 32'(count), 32'd6);
      chk("fill6_ready", 32'(in_ready), 32'd1);
      tick();
      enq(2'b10, 7'd17, 7'd0);
      @(negedge clk);
      chk("fill7_count", 32'(count), 32'd7);
      chk("fill7_ready", 32'(in_ready), 32'd0);
      tick();
      enq(2'b11, 7'd1, 7'd1);
      @(negedge clk);
      chk("full_hold_count", 32'(count), 32'd7);
      tick();
      even_ready = 1'b1;
      odd_ready  = 1'b1;
      flush      = 1'b1;
      @(negedge clk);
      chk("flush_fire", 32'(issue_fire), 32'd0);
      tick();
      flush = 1'b0;
      @(negedge clk);
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_valid", 32'({even_valid, odd_valid}), 32'd0);
      tick();

      // Reset in the middle of traffic
      even_ready = 1'b0;
      odd_ready  = 1'b0;
      enq(2'b11, 7'd1, 7'd81);
      reset = 1'b1;
      tick();
      reset      = 1'b0;
      even_ready = 1'b1;
      odd_ready  = 1'b1;
      @(negedge clk);
      chk("midrst_count", 32'(count), 32'd0);
      chk("midrst_valid", 32'({even_valid, odd_valid}), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      tick();

      // Random traffic with pointer wrap; the scoreboard checks every issue
      for (int c = 0; c < 80; c++) begin
         r = $urandom_range(0, 2);
         in_valid    = (r == 0) ? 2'b00 : ((r == 1) ? 2'b10 : 2'b11);
         in_opcode0  = ops_tbl[$urandom_range(0, 11)];
         in_opcode1  = ops_tbl[$urandom_range(0, 11)];
         in_payload0 = $urandom;
         in_payload1 = $urandom;
         even_ready  = 1'($urandom);
         odd_ready   = 1'($urandom);
         flush       = ($urandom_range(0, 15) == 0);
         tick();
      end
      in_valid   = 2'b00;
      flush      = 1'b0;
      even_ready = 1'b1;
      odd_ready  = 1'b1;
      drained    = 1'b0;
      for (int c = 0; c < 40 && !drained; c++) begin
         @(negedge clk);
         if (count == '0) drained = 1'b1;
      end
      if (!drained) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain_timeout: got count=%0d, expected 0 within 40 cycles", count);
      end
      chk("drain_sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
